// File: rtl/vehicle_sensor_frontend.sv
// rtl/vehicle_sensor_frontend.sv - debounced loop/treadle front-end with axle classification for the toll controller
// Three identical debouncers feed an EMPTY/OCCUPIED/WAIT_EXIT/FAULT sequencer; all controller outputs are registered.
module vehicle_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_loop_raw,
  input  logic       exit_loop_raw,
  input  logic       axle_raw,
  output logic       vehicle_detect,
  output logic [1:0] vehicle_class,
  output logic       vehicle_passgate,
  output logic       fault,
  output logic [2:0] axle_count
);

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_OCCUPIED  = 2'd1,
    S_WAIT_EXIT = 2'd2,
    S_FAULT     = 2'd3
  } state_t;

  // bit 0 entry loop, bit 1 exit loop, bit 2 axle treadle
  logic [2:0]  w_raw;
  logic [2:0]  r_db;
  logic [2:0]  r_db_d;
  logic [7:0]  r_cnt [3];

  logic        w_entry_fall;
  logic        w_exit_rise;
  logic        w_axle_rise;
  logic        w_timeout;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_timer;
  logic [2:0]  r_axle;

  logic        w_detect;
  logic [1:0]  w_class_next;
  logic        w_fault_next;
  logic        r_detect;
  logic [1:0]  r_class;
  logic        r_pass;
  logic        r_fault;

  assign w_raw = {axle_raw, exit_loop_raw, entry_loop_raw};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_db   <= 3'b000;
      r_db_d <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= 8'd0;
      end
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] == r_db[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_entry_fall = r_db_d[0] & ~r_db[0];
  assign w_exit_rise  = r_db[1] & ~r_db_d[1];
  assign w_axle_rise  = r_db[2] & ~r_db_d[2];
  assign w_timeout    = (r_state == S_OCCUPIED) && (r_timer == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (r_db[0]) begin
          w_next = S_OCCUPIED;
        end
      end
      S_OCCUPIED: begin
        // timeout wins over a same-cycle entry release
        if (w_timeout) begin
          w_next = S_FAULT;
        end else if (w_entry_fall) begin
          w_next = (r_axle >= 3'd2) ? S_WAIT_EXIT : S_EMPTY;
        end
      end
      S_WAIT_EXIT: begin
        if (w_exit_rise) begin
          w_next = S_EMPTY;
        end
      end
      S_FAULT: begin
        if (!r_db[0]) begin
          w_next = S_EMPTY;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    w_detect     = 1'b0;
    w_class_next = r_class;
    if ((r_state == S_OCCUPIED) && (w_next == S_WAIT_EXIT)) begin
      w_detect = 1'b1;
      case (r_axle)
        3'd2:    w_class_next = 2'd0;
        3'd3:    w_class_next = 2'd2;
        default: w_class_next = 2'd1;
      endcase
    end
    w_fault_next = (w_next == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= 16'd0;
      r_axle  <= 3'd0;
    end else if ((r_state == S_EMPTY) && (w_next == S_OCCUPIED)) begin
      r_timer <= 16'd0;
      r_axle  <= 3'd0;
    end else if (r_state == S_OCCUPIED) begin
      r_timer <= r_timer + 16'd1;
      if (w_axle_rise && (r_axle != 3'd7)) begin
        r_axle <= r_axle + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_detect <= 1'b0;
      r_class  <= 2'd0;
      r_pass   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_detect <= w_detect;
      r_class  <= w_class_next;
      r_pass   <= w_exit_rise;
      r_fault  <= w_fault_next;
    end
  end

  assign vehicle_detect   = r_detect;
  assign vehicle_class    = r_class;
  assign vehicle_passgate = r_pass;
  assign fault            = r_fault;
  assign axle_count       = r_axle;

endmodule

// File: tb/tb_vehicle_sensor_frontend.sv
// tb/tb_vehicle_sensor_frontend.sv - directed and randomized bench for vehicle_sensor_frontend
// A behavioural model predicts every output after every clock edge; directed steps add timing checks.
module tb_vehicle_sensor_frontend;

  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_loop_raw;
  logic       exit_loop_raw;
  logic       axle_raw;
  logic       vehicle_detect;
  logic [1:0] vehicle_class;
  logic       vehicle_passgate;
  logic       fault;
  logic [2:0] axle_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vehicle_sensor_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .entry_loop_raw  (entry_loop_raw),
    .exit_loop_raw   (exit_loop_raw),
    .axle_raw        (axle_raw),
    .vehicle_detect  (vehicle_detect),
    .vehicle_class   (vehicle_class),
    .vehicle_passgate(vehicle_passgate),
    .fault           (fault),
    .axle_count      (axle_count)
  );

  // model: mode 0 empty, 1 vehicle on loop, 2 awaiting exit, 3 faulted
  int cyc = 0;
  bit m_db [3];
  bit m_prev [3];
  int m_run [3];
  int m_mode = 0;
  int m_start = 0;
  int m_axles = 0;
  bit e_det = 0;
  bit e_pass = 0;
  bit e_fault = 0;
  int e_class = 0;

  int det_count = 0;
  int pass_count = 0;
  int last_det_cyc = -1;
  int last_pass_cyc = -1;
  int first_fault_cyc = -1;
  bit prev_fault = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit raw0, input bit raw1, input bit raw2);
    bit raw [3];
    bit rise [3];
    bit entry_fell;
    int old_mode;
    raw[0] = raw0;
    raw[1] = raw1;
    raw[2] = raw2;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_db[i] = 0;
        m_prev[i] = 0;
        m_run[i] = 0;
      end
      m_mode = 0;
      m_axles = 0;
      e_det = 0;
      e_pass = 0;
      e_fault = 0;
      e_class = 0;
      return;
    end
    for (int i = 0; i < 3; i++) rise[i] = m_db[i] && !m_prev[i];
    entry_fell = !m_db[0] && m_prev[0];
    old_mode = m_mode;
    e_det = 0;
    e_pass = rise[1];
    case (m_mode)
      0: if (m_db[0]) begin
        m_mode = 1;
        m_start = cyc;
        m_axles = 0;
      end
      1: if (cyc - m_start > TO) begin
        m_mode = 3;
      end else if (entry_fell) begin
        if (m_axles >= 2) begin
          e_det = 1;
          e_class = (m_axles == 2) ? 0 : (m_axles == 3) ? 2 : 1;
          m_mode = 2;
        end else begin
          m_mode = 0;
        end
      end
      2: if (rise[1]) m_mode = 0;
      default: if (!m_db[0]) m_mode = 0;
    endcase
    if (old_mode == 1 && rise[2] && m_axles < 7) m_axles++;
    e_fault = (m_mode == 3);
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_db[i];
      if (raw[i] == m_db[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i] = !m_db[i];
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ex, input bit ax);
    reset = rst;
    entry_loop_raw = en;
    exit_loop_raw = ex;
    axle_raw = ax;
    @(posedge clk);
    cyc++;
    model_edge(rst, en, ex, ax);
    #1;
    chk("detect", vehicle_detect, e_det);
    chk("passgate", vehicle_passgate, e_pass);
    chk("class", vehicle_class, e_class);
    chk("fault", fault, e_fault);
    chk("axle_count", axle_count, m_axles);
    if (vehicle_detect === 1'b1) begin
      det_count++;
      last_det_cyc = cyc;
    end
    if (vehicle_passgate === 1'b1) begin
      pass_count++;
      last_pass_cyc = cyc;
    end
    if (fault === 1'b1 && !prev_fault && first_fault_cyc < 0) first_fault_cyc = cyc;
    prev_fault = (fault === 1'b1);
  endtask

  task automatic hold(input int n, input bit en, input bit ex, input bit ax);
    for (int i = 0; i < n; i++) step(1'b1, en, ex, ax);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      hold(hi, 1'b1, 1'b0, 1'b1);
      hold(lo, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic exit_pulse();
    hold(6, 1'b0, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_vehicle(input string tag, input int n, input int hi, input int lo,
                               input int exp_det, input int exp_class, input int exp_axles);
    int d0;
    d0 = det_count;
    hold(6, 1'b1, 1'b0, 1'b0);
    pulses(n, hi, lo);
    hold(6, 1'b1, 1'b0, 1'b0);
    hold(8, 1'b0, 1'b0, 1'b0);
    chk({tag, "_detects"}, det_count - d0, exp_det);
    chk({tag, "_axles"}, axle_count, exp_axles);
    if (exp_det != 0) chk({tag, "_class"}, vehicle_class, exp_class);
    exit_pulse();
  endtask

  initial begin
    int t0;
    int d0;
    int p0;
    bit r_en;
    bit r_ex;
    bit r_ax;
    int len;

    // reset state
    hold(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_detect", vehicle_detect, 0);
    chk("rst_passgate", vehicle_passgate, 0);
    chk("rst_class", vehicle_class, 0);
    chk("rst_fault", fault, 0);
    chk("rst_axles", axle_count, 0);

    // car: 40 cycles on the loop, two 6-cycle axles
    d0 = det_count;
    hold(8, 1'b1, 1'b0, 1'b0);
    pulses(2, 6, 6);
    hold(8, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    hold(10, 1'b0, 1'b0, 1'b0);
    chk("car_detects", det_count - d0, 1);
    chk("car_latency", last_det_cyc, t0 + DB + 1);
    chk("car_class", vehicle_class, 0);
    chk("car_axles", axle_count, 2);
    p0 = pass_count;
    t0 = cyc;
    exit_pulse();
    chk("car_passgates", pass_count - p0, 1);
    chk("car_pass_latency", last_pass_cyc, t0 + DB + 1);

    check_vehicle("truck5", 5, 5, 5, 1, 1, 5);
    check_vehicle("bus3", 3, 5, 5, 1, 2, 3);
    check_vehicle("sat9", 9, 4, 4, 1, 1, 7);
    check_vehicle("truck4", 4, 5, 5, 1, 1, 4);

    // glitches shorter than the debounce window
    d0 = det_count;
    p0 = pass_count;
    hold(3, 1'b1, 1'b1, 1'b1);
    hold(8, 1'b0, 1'b0, 1'b0);
    chk("glitch_detects", det_count - d0, 0);
    chk("glitch_passgates", pass_count - p0, 0);
    check_vehicle("glitch_axles", 3, 3, 5, 0, 0, 0);
    check_vehicle("ghost1", 1, 5, 5, 0, 0, 1);

    // evasion: exit activity with no vehicle classified
    d0 = det_count;
    p0 = pass_count;
    exit_pulse();
    chk("evasion_passgates", pass_count - p0, 1);
    chk("evasion_detects", det_count - d0, 0);

    // entry release and exit arrival debounced together
    d0 = det_count;
    p0 = pass_count;
    hold(6, 1'b1, 1'b0, 1'b0);
    pulses(2, 5, 5);
    hold(6, 1'b1, 1'b0, 1'b0);
    hold(8, 1'b0, 1'b1, 1'b0);
    chk("simul_detects", det_count - d0, 1);
    chk("simul_passgates", pass_count - p0, 1);
    chk("simul_same_cycle", last_det_cyc, last_pass_cyc);
    hold(8, 1'b0, 1'b0, 1'b0);
    d0 = det_count;
    hold(6, 1'b1, 1'b0, 1'b0);
    pulses(2, 5, 5);
    hold(6, 1'b1, 1'b0, 1'b0);
    hold(8, 1'b0, 1'b0, 1'b0);
    chk("wait_exit_ignores_entry", det_count - d0, 0);
    exit_pulse();
    check_vehicle("after_wait", 2, 5, 5, 1, 0, 2);

    // occupancy timeout
    d0 = det_count;
    first_fault_cyc = -1;
    t0 = cyc;
    hold(200, 1'b1, 1'b0, 1'b0);
    chk("timeout_rise_cycle", first_fault_cyc, t0 + DB + TO + 2);
    chk("timeout_fault_held", fault, 1);
    hold(10, 1'b0, 1'b0, 1'b0);
    chk("timeout_fault_clear", fault, 0);
    chk("timeout_detects", det_count - d0, 0);

    check_vehicle("truck_pre_rst", 5, 5, 5, 1, 1, 5);

    // reset while a vehicle is on the loop
    hold(6, 1'b1, 1'b0, 1'b0);
    pulses(2, 5, 5);
    chk("pre_rst_axles", axle_count, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_detect", vehicle_detect, 0);
    chk("mid_rst_passgate", vehicle_passgate, 0);
    chk("mid_rst_class", vehicle_class, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_axles", axle_count, 0);
    d0 = det_count;
    hold(10, 1'b1, 1'b0, 1'b0);
    chk("reacq_axles", axle_count, 0);
    pulses(2, 5, 5);
    hold(4, 1'b1, 1'b0, 1'b0);
    hold(8, 1'b0, 1'b0, 1'b0);
    chk("reacq_detects", det_count - d0, 1);
    chk("reacq_class", vehicle_class, 0);
    exit_pulse();

    // randomized segments checked cycle by cycle against the model
    for (int s = 0; s < 250; s++) begin
      r_en = 1'($urandom_range(0, 1));
      r_ex = 1'($urandom_range(0, 1));
      r_ax = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 59) == 0) step(1'b0, r_en, r_ex, r_ax);
      hold(len, r_en, r_ex, r_ax);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
